// File: rtl/spi_ram_arbiter_if.sv
// Requester, RAM and status signals of the SPI/host RAM arbiter.
// slave: the arbiter side; master: the requesters plus the RAM.
interface spi_ram_arbiter_if;
  logic [9:0] req0_din;
  logic       req0_valid;
  logic       req0_ready;
  logic [7:0] req0_dout;
  logic       req0_dvalid;
  logic [9:0] req1_din;
  logic       req1_valid;
  logic       req1_ready;
  logic [7:0] req1_dout;
  logic       req1_dvalid;
  logic [9:0] ram_din;
  logic       ram_rx_valid;
  logic [7:0] ram_dout;
  logic       ram_tx_valid;
  logic       owner;
  logic       busy;
  logic       err;

  modport slave (
    input  req0_din, req0_valid, req1_din, req1_valid, ram_dout, ram_tx_valid,
    output req0_ready, req0_dout, req0_dvalid, req1_ready, req1_dout, req1_dvalid,
    output ram_din, ram_rx_valid, owner, busy, err
  );

  modport master (
    output req0_din, req0_valid, req1_din, req1_valid, ram_dout, ram_tx_valid,
    input  req0_ready, req0_dout, req0_dvalid, req1_ready, req1_dout, req1_dvalid,
    input  ram_din, ram_rx_valid, owner, busy, err
  );
endinterface

// File: rtl/spi_ram_arbiter.sv
// Locks a single-port command RAM to one of two requesters from an address
// command until its data command completes; returns read data; times out stalls.
module spi_ram_arbiter #(
  parameter int unsigned TIMEOUT = 15
) (
  input logic              clk,
  input logic              rst_n,
  spi_ram_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LOCK_WR, LOCK_RD, WAIT_DATA} state_t;

  // Release fires on the idle cycle that would take the count to TIMEOUT.
  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  logic       owner_q;
  logic       rr;
  logic [7:0] timer;
  logic [1:0] valid;
  logic [1:0] ready;
  logic       winner;
  logic       acc_idx;
  logic [9:0] word;
  logic       any_acc;

  assign valid = {bus.req1_valid, bus.req0_valid};

  always_comb begin
    winner = valid[1] & (~valid[0] | rr);
    ready  = '0;
    if (rst_n) begin
      case (state)
        IDLE:             ready[winner]  = valid[winner];
        LOCK_WR, LOCK_RD: ready[owner_q] = 1'b1;
        default:          ready          = '0;
      endcase
    end
  end

  assign acc_idx        = (state == IDLE) ? winner : owner_q;
  assign word           = acc_idx ? bus.req1_din : bus.req0_din;
  assign any_acc        = |(valid & ready);
  assign bus.req0_ready = ready[0];
  assign bus.req1_ready = ready[1];
  assign bus.owner      = owner_q;
  assign bus.busy       = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      owner_q          <= 1'b0;
      rr               <= 1'b0;
      timer            <= '0;
      bus.ram_din      <= '0;
      bus.ram_rx_valid <= 1'b0;
      bus.req0_dout    <= '0;
      bus.req0_dvalid  <= 1'b0;
      bus.req1_dout    <= '0;
      bus.req1_dvalid  <= 1'b0;
      bus.err          <= 1'b0;
    end else begin
      bus.ram_rx_valid <= 1'b0;
      bus.req0_dvalid  <= 1'b0;
      bus.req1_dvalid  <= 1'b0;
      bus.err          <= 1'b0;
      case (state)
        IDLE: begin
          timer <= '0;
          if (any_acc) begin
            if (word[8] == 1'b0) begin
              bus.ram_din      <= word;
              bus.ram_rx_valid <= 1'b1;
              owner_q          <= winner;
              state            <= word[9] ? LOCK_RD : LOCK_WR;
            end else begin
              bus.err <= 1'b1;
            end
          end
        end
        LOCK_WR, LOCK_RD: begin
          if (any_acc) begin
            timer <= '0;
            case (word[9:8])
              2'b00: begin
                bus.ram_din      <= word;
                bus.ram_rx_valid <= 1'b1;
                state            <= LOCK_WR;
              end
              2'b10: begin
                bus.ram_din      <= word;
                bus.ram_rx_valid <= 1'b1;
                state            <= LOCK_RD;
              end
              2'b01: begin
                if (state == LOCK_WR) begin
                  bus.ram_din      <= word;
                  bus.ram_rx_valid <= 1'b1;
                  state            <= IDLE;
                  rr               <= ~owner_q;
                end else begin
                  bus.err <= 1'b1;
                end
              end
              default: begin
                if (state == LOCK_RD) begin
                  bus.ram_din      <= word;
                  bus.ram_rx_valid <= 1'b1;
                  state            <= WAIT_DATA;
                end else begin
                  bus.err <= 1'b1;
                end
              end
            endcase
          end else if (timer == TIMER_LAST) begin
            state   <= IDLE;
            rr      <= ~owner_q;
            timer   <= '0;
            bus.err <= 1'b1;
          end else begin
            timer <= timer + 8'd1;
          end
        end
        default: begin
          // Returned data takes precedence over a coincident timeout.
          if (bus.ram_tx_valid) begin
            if (owner_q) begin
              bus.req1_dout   <= bus.ram_dout;
              bus.req1_dvalid <= 1'b1;
            end else begin
              bus.req0_dout   <= bus.ram_dout;
              bus.req0_dvalid <= 1'b1;
            end
            state <= IDLE;
            rr    <= ~owner_q;
            timer <= '0;
          end else if (timer == TIMER_LAST) begin
            state   <= IDLE;
            rr      <= ~owner_q;
            timer   <= '0;
            bus.err <= 1'b1;
          end else begin
            timer <= timer + 8'd1;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Directed scenarios with literal expectations, then random traffic, all
// tracked every cycle by a table-driven transaction model of the arbiter.
module tb_spi_ram_arbiter;
  localparam int TO = 3;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;

  spi_ram_arbiter_if bus ();

  spi_ram_arbiter #(.TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Phase 0 idle, 1 write-locked, 2 read-locked, 3 awaiting data.
  // Entry [phase][cmd]: next phase, or -1 when the word is dropped.
  int tbl [3][4] = '{'{1, -1, 2, -1}, '{1, 0, 2, -1}, '{1, -1, 2, 3}};
  int         ph;
  int         m_tmr;
  int         nx;
  bit         m_own;
  bit         m_rr;
  bit         w;
  logic [1:0] v;
  logic [1:0] er;
  logic [9:0] din [2];
  logic [9:0] e_din;
  bit         e_rx;
  bit         e_err;
  logic [7:0] e_dout [2];
  bit         e_dv [2];

  task automatic m_release();
    ph    = 0;
    m_rr  = ~m_own;
    m_tmr = 0;
  endtask

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        ph = 0; m_own = 0; m_rr = 0; m_tmr = 0;
        e_din = '0; e_rx = 0; e_err = 0;
        e_dout[0] = '0; e_dout[1] = '0; e_dv[0] = 0; e_dv[1] = 0;
      end
      chk("ram_din", bus.ram_din, e_din);
      chk("ram_rx_valid", bus.ram_rx_valid, e_rx);
      chk("err", bus.err, e_err);
      chk("busy", bus.busy, (ph != 0));
      chk("req0_dout", bus.req0_dout, e_dout[0]);
      chk("req1_dout", bus.req1_dout, e_dout[1]);
      chk("req0_dvalid", bus.req0_dvalid, e_dv[0]);
      chk("req1_dvalid", bus.req1_dvalid, e_dv[1]);
      if (ph != 0) chk("owner", bus.owner, m_own);

      v      = {bus.req1_valid, bus.req0_valid};
      din[0] = bus.req0_din;
      din[1] = bus.req1_din;
      w      = (v == 2'b11) ? m_rr : v[1];
      er     = '0;
      if (rst_n) begin
        if (ph == 0) er[w] = v[w];
        else if (ph < 3) er[m_own] = 1'b1;
      end
      chk("req0_ready", bus.req0_ready, er[0]);
      chk("req1_ready", bus.req1_ready, er[1]);

      if (rst_n) begin
        e_rx = 0; e_err = 0; e_dv[0] = 0; e_dv[1] = 0;
        if (ph == 0) begin
          if (v[w]) begin
            nx = tbl[0][din[w][9:8]];
            if (nx < 0) e_err = 1;
            else begin
              e_din = din[w]; e_rx = 1; m_own = w; ph = nx; m_tmr = 0;
            end
          end
        end else if (ph == 3) begin
          if (bus.ram_tx_valid) begin
            e_dv[m_own] = 1; e_dout[m_own] = bus.ram_dout; m_release();
          end else begin
            m_tmr++;
            if (m_tmr == TO) begin m_release(); e_err = 1; end
          end
        end else begin
          if (v[m_own]) begin
            m_tmr = 0;
            nx = tbl[ph][din[m_own][9:8]];
            if (nx < 0) e_err = 1;
            else begin
              e_din = din[m_own]; e_rx = 1;
              if (nx == 0) m_release(); else ph = nx;
            end
          end else begin
            m_tmr++;
            if (m_tmr == TO) begin m_release(); e_err = 1; end
          end
        end
      end
    end
  end

  task automatic drv(input bit v0, input logic [9:0] d0, input bit v1, input logic [9:0] d1);
    bus.req0_valid = v0; bus.req0_din = d0;
    bus.req1_valid = v1; bus.req1_din = d1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  bit a0, a1;

  initial begin
    rst_n = 1'b0;
    drv(0, '0, 0, '0);
    bus.ram_tx_valid = 1'b0;
    bus.ram_dout     = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("reset_busy", bus.busy, 0);
    chk("reset_rx", bus.ram_rx_valid, 0);
    chk("reset_err", bus.err, 0);

    // Write pair from requester 0.
    drv(1, 10'h012, 0, '0); #1;
    chk("t1_rdy0", bus.req0_ready, 1);
    tick();
    chk("t1_rx_a", bus.ram_rx_valid, 1); chk("t1_din_a", bus.ram_din, 10'h012);
    chk("t1_busy", bus.busy, 1); chk("t1_owner", bus.owner, 0);
    drv(1, 10'h1A5, 0, '0); tick();
    chk("t1_rx_d", bus.ram_rx_valid, 1); chk("t1_din_d", bus.ram_din, 10'h1A5);
    chk("t1_idle", bus.busy, 0);

    // rr = 1 now: requester 1 wins, requester 0 waits pending.
    drv(1, 10'h0AA, 1, 10'h040); #1;
    chk("rr1_rdy1", bus.req1_ready, 1); chk("rr1_rdy0", bus.req0_ready, 0);
    tick();
    chk("rr1_owner", bus.owner, 1); chk("rr1_din", bus.ram_din, 10'h040);
    chk("rr1_pend0", bus.req0_ready, 0);
    drv(1, 10'h0AA, 1, 10'h1CC); tick();
    chk("rr1_rel", bus.busy, 0); chk("rr1_next0", bus.req0_ready, 1);
    drv(1, 10'h0AA, 0, '0); tick();
    chk("rr1_own0", bus.owner, 0); chk("rr1_din0", bus.ram_din, 10'h0AA);
    drv(1, 10'h1FF, 0, '0); tick();
    chk("rr1_rel0", bus.busy, 0);

    // Read transaction by requester 0.
    drv(1, 10'h212, 0, '0); tick();
    chk("t2_din_a", bus.ram_din, 10'h212); chk("t2_busy", bus.busy, 1);
    drv(1, 10'h300, 0, '0); tick();
    chk("t2_din_r", bus.ram_din, 10'h300); chk("t2_rx", bus.ram_rx_valid, 1);
    drv(0, '0, 0, '0); bus.ram_tx_valid = 1'b1; bus.ram_dout = 8'hA5; tick();
    bus.ram_tx_valid = 1'b0;
    chk("t2_dv0", bus.req0_dvalid, 1); chk("t2_dout0", bus.req0_dout, 8'hA5);
    chk("t2_dv1", bus.req1_dvalid, 0); chk("t2_idle", bus.busy, 0);

    // Dropped data commands.
    drv(1, 10'h133, 0, '0); tick();
    chk("t5_err_a", bus.err, 1); chk("t5_rx_a", bus.ram_rx_valid, 0); chk("t5_idle", bus.busy, 0);
    drv(1, 10'h001, 0, '0); tick();
    chk("t5_lock", bus.busy, 1);
    drv(1, 10'h3AA, 0, '0); tick();
    chk("t5_err_b", bus.err, 1); chk("t5_rx_b", bus.ram_rx_valid, 0);
    chk("t5_din_b", bus.ram_din, 10'h001); chk("t5_still", bus.busy, 1);
    drv(1, 10'h100, 0, '0); tick();
    chk("t5_rel", bus.busy, 0); chk("t5_noerr", bus.err, 0);

    // Timeout of a silent requester 1.
    drv(0, '0, 1, 10'h005); tick();
    chk("t4_own", bus.owner, 1); chk("t4_busy0", bus.busy, 1);
    drv(0, '0, 0, '0); tick();
    chk("t4_busy1", bus.busy, 1); chk("t4_rx1", bus.ram_rx_valid, 0);
    tick();
    chk("t4_busy2", bus.busy, 1); chk("t4_err2", bus.err, 0);
    tick();
    chk("t4_rel", bus.busy, 0); chk("t4_err", bus.err, 1); chk("t4_rx", bus.ram_rx_valid, 0);

    // rr = 0 after timeout: requester 0 wins, requester 1 holds until release.
    drv(1, 10'h011, 1, 10'h040); #1;
    chk("t3_rdy0", bus.req0_ready, 1); chk("t3_rdy1", bus.req1_ready, 0);
    tick();
    chk("t3_own0", bus.owner, 0); chk("t3_hold1", bus.req1_ready, 0);
    drv(1, 10'h1BB, 1, 10'h040); tick();
    chk("t3_rel", bus.busy, 0);
    drv(0, '0, 1, 10'h040); #1;
    chk("t3_rdy1b", bus.req1_ready, 1);
    tick();
    chk("t3_own1", bus.owner, 1); chk("t3_din", bus.ram_din, 10'h040);
    drv(0, '0, 1, 10'h1CC); tick();
    chk("t3_done", bus.busy, 0);

    // Reset during WAIT_DATA with data arriving.
    drv(1, 10'h201, 0, '0); tick();
    drv(1, 10'h300, 0, '0); tick();
    chk("t6_wait", bus.busy, 1);
    drv(0, '0, 0, '0); bus.ram_tx_valid = 1'b1; bus.ram_dout = 8'h5A;
    rst_n = 1'b0; #1;
    chk("t6_busy", bus.busy, 0); chk("t6_din", bus.ram_din, 0);
    chk("t6_dout0", bus.req0_dout, 0); chk("t6_err", bus.err, 0);
    chk("t6_rx", bus.ram_rx_valid, 0); chk("t6_owner", bus.owner, 0);
    tick();
    chk("t6_nodv", bus.req0_dvalid, 0);
    bus.ram_tx_valid = 1'b0; rst_n = 1'b1; tick();
    chk("t6_idle", bus.busy, 0); chk("t6_nodv2", bus.req0_dvalid, 0);
    drv(1, 10'h011, 1, 10'h011); #1;
    chk("t6_rr0", bus.req0_ready, 1); chk("t6_rr0b", bus.req1_ready, 0);
    drv(0, '0, 0, '0);

    // Random traffic; a requester holds its word until it is accepted.
    repeat (3000) begin
      @(negedge clk);
      a0 = bus.req0_valid & bus.req0_ready;
      a1 = bus.req1_valid & bus.req1_ready;
      tick();
      if (!bus.req0_valid || a0) begin
        bus.req0_valid = ($urandom_range(0, 2) != 0);
        bus.req0_din   = 10'($urandom);
      end
      if (!bus.req1_valid || a1) begin
        bus.req1_valid = ($urandom_range(0, 2) != 0);
        bus.req1_din   = 10'($urandom);
      end
      bus.ram_tx_valid = ($urandom_range(0, 3) == 0);
      bus.ram_dout     = 8'($urandom);
    end
    drv(0, '0, 0, '0);
    bus.ram_tx_valid = 1'b0;
    repeat (8) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
